// File: rtl/tx_eth_pkg.sv
// Shared constants and state encoding for the Ethernet transmit MAC.
package tx_eth_pkg;

  // Transmit sequencer states, listed in wire order.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_HDR  = 3'd2,
    ST_PAY  = 3'd3,
    ST_PAD  = 3'd4,
    ST_FCS  = 3'd5,
    ST_DROP = 3'd6,
    ST_IFG  = 3'd7
  } tx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         PRE_LEN       = 8;   // seven preamble bytes plus the SFD
  localparam int         HDR_LEN       = 14;
  localparam int         FCS_LEN       = 4;

  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY_REF = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected IEEE 802.3 CRC-32.
module crc32_d8
  import tx_eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Fold the byte in LSB first, one polynomial division step per bit.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments and gives every
    // output a value up front, so no path can infer a latch.
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY_REF;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/tx_mac.sv
// Ethernet II transmit MAC: wraps an IP byte stream with preamble/SFD,
// MAC header, zero padding and FCS, then enforces the inter-frame gap.
module tx_mac
  import tx_eth_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE   = 16'h0800,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          IFG_CYCLES  = 12
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_areset,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [15:0] tx_frame_cnt
);

  localparam int             IFG_W        = $clog2(IFG_CYCLES + 1);
  localparam logic [IFG_W-1:0] IFG_LAST   = IFG_W'(IFG_CYCLES - 1);
  localparam logic [10:0]    MIN_PAY_W    = 11'(MIN_PAYLOAD);
  localparam logic [3:0]     PRE_SFD_IDX  = 4'(PRE_LEN - 1);
  localparam logic [3:0]     HDR_LAST     = 4'(HDR_LEN - 1);
  localparam logic [3:0]     FCS_LAST     = 4'(FCS_LEN - 1);

  tx_state_e        state;
  logic [3:0]       byte_cnt;   // position inside preamble, header or FCS
  logic [10:0]      pay_cnt;    // payload plus pad bytes sent so far
  logic [10:0]      pay_next;
  logic [IFG_W-1:0] ifg_cnt;
  logic [111:0]     hdr_sr;     // latched header, shifted out MSB byte first
  logic [31:0]      crc;
  logic [31:0]      crc_next;
  logic [7:0]       crc_data;

  // The start-of-packet marker carries no information the MAC needs.
  logic unused_tuser;
  assign unused_tuser = s_axis_tuser;

  // Byte folded into the CRC this cycle: header, live payload or pad zero.
  always_comb begin
    case (state)
      ST_HDR:  crc_data = hdr_sr[111:104];
      ST_PAY:  crc_data = s_axis_tdata;
      default: crc_data = 8'h00;
    endcase
  end

  // Saturating payload count so very long frames cannot wrap back below the minimum.
  always_comb begin
    pay_next = (pay_cnt == 11'h7FF) ? pay_cnt : pay_cnt + 11'd1;
  end

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (crc_data),
    .crc_out (crc_next)
  );

  // Frame sequencer; every GMII output is registered here, so each edge
  // decides the byte that appears on the wire during the following cycle.
  always_ff @(posedge s_axis_aclk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // branch below reads the pre-edge values of the registers.
    if (s_axis_areset) begin
      state         <= ST_IDLE;
      byte_cnt      <= '0;
      pay_cnt       <= '0;
      ifg_cnt       <= '0;
      hdr_sr        <= '0;
      crc           <= '0;
      s_axis_tready <= 1'b0;
      gmii_txd      <= 8'h00;
      gmii_tx_en    <= 1'b0;
      gmii_tx_er    <= 1'b0;
      tx_frame_cnt  <= '0;
    end else begin
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (s_axis_tvalid) begin
            hdr_sr     <= {dst_mac, src_mac, ETHERTYPE};
            gmii_txd   <= PREAMBLE_BYTE;
            gmii_tx_en <= 1'b1;
            byte_cnt   <= 4'd1;
            state      <= ST_PRE;
          end
        end

        ST_PRE: begin
          gmii_tx_en <= 1'b1;
          if (byte_cnt == PRE_SFD_IDX) begin
            gmii_txd <= SFD_BYTE;
            crc      <= CRC_INIT;
            byte_cnt <= '0;
            state    <= ST_HDR;
          end else begin
            gmii_txd <= PREAMBLE_BYTE;
            byte_cnt <= byte_cnt + 4'd1;
          end
        end

        ST_HDR: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= hdr_sr[111:104];
          hdr_sr     <= {hdr_sr[103:0], 8'h00};
          crc        <= crc_next;
          if (byte_cnt == HDR_LAST) begin
            // Open the upstream port now so payload byte 0 lands on the first PAY edge.
            s_axis_tready <= 1'b1;
            pay_cnt       <= '0;
            byte_cnt      <= '0;
            state         <= ST_PAY;
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
          end
        end

        ST_PAY: begin
          gmii_tx_en <= 1'b1;
          // tready is always high here, so tvalid alone marks an accepted byte.
          if (s_axis_tvalid) begin
            gmii_txd <= s_axis_tdata;
            crc      <= crc_next;
            pay_cnt  <= pay_next;
            if (s_axis_tlast) begin
              s_axis_tready <= 1'b0;
              byte_cnt      <= '0;
              state         <= (pay_next < MIN_PAY_W) ? ST_PAD : ST_FCS;
            end
          end else begin
            // Underrun: the wire cannot wait, so poison the frame and drain the rest.
            gmii_tx_er <= 1'b1;
            state      <= ST_DROP;
          end
        end

        ST_PAD: begin
          gmii_tx_en <= 1'b1;
          crc        <= crc_next;
          pay_cnt    <= pay_next;
          if (pay_next >= MIN_PAY_W) state <= ST_FCS;
        end

        ST_FCS: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= ~crc[7:0];
          crc        <= {8'h00, crc[31:8]};
          if (byte_cnt == FCS_LAST) begin
            tx_frame_cnt <= tx_frame_cnt + 16'd1;
            ifg_cnt      <= '0;
            state        <= ST_IFG;
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
          end
        end

        ST_DROP: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            s_axis_tready <= 1'b0;
            ifg_cnt       <= '0;
            state         <= ST_IFG;
          end
        end

        ST_IFG: begin
          if (ifg_cnt == IFG_LAST) state <= ST_IDLE;
          else                     ifg_cnt <= ifg_cnt + IFG_W'(1);
        end
      endcase
    end
  end

endmodule
